// File: rtl/invader_renderer_if.sv
// -----------------------------------------------------------------------------
// invader_renderer_if
//
// Pixel and kill bus between the video front end / collision logic and the
// invader renderer.
//
//   draw        pixel is inside the visible area
//   pixelx      visible x coordinate (0..799)
//   pixely      visible y coordinate (0..599)
//   kill_valid  one-cycle kill strobe from the collision logic
//   kill_row    row of the invader to kill
//   kill_col    column of the invader to kill
//   rgb         rendered pixel colour, RRRGGGBB
//   rgb_valid   draw delayed to line up with rgb
//
// The master drives pixels and kills; the slave (the renderer) returns colour.
// -----------------------------------------------------------------------------
interface invader_renderer_if;
    logic        draw;
    logic [10:0] pixelx;
    logic [10:0] pixely;
    logic        kill_valid;
    logic [1:0]  kill_row;
    logic [2:0]  kill_col;
    logic [7:0]  rgb;
    logic        rgb_valid;

    modport master (
        output draw, pixelx, pixely, kill_valid, kill_row, kill_col,
        input  rgb, rgb_valid
    );

    modport slave (
        input  draw, pixelx, pixely, kill_valid, kill_row, kill_col,
        output rgb, rgb_valid
    );
endinterface

// File: rtl/invader_renderer.sv
// -----------------------------------------------------------------------------
// invader_renderer
//
// Pixel-generation stage that sits directly behind the VGA timing controller.
// Owns the invader formation (alive bitmap, position, marching FSM), accepts
// kill requests and renders the formation as registered 3-3-2 RGB with a fixed
// two-cycle latency, one pixel per clock.
//
// Ports:
//   clk          pixel clock (40 MHz)
//   clear_n      asynchronous active-low reset
//   vsync        frame sync; each rising edge is one frame tick
//   bus          invader_renderer_if.slave: draw/pixelx/pixely in,
//                kill_valid/kill_row/kill_col in, rgb/rgb_valid out
//   formation_x  current formation left edge
//   formation_y  current formation top edge
//   alive_count  number of live invaders
//   step_pulse   one-cycle pulse on every formation step
//   landed       sticky, formation reached the landing line
//   all_dead     no invaders left
//
// Build option:
//   SPEEDUP_EN   when defined, the step period in frames is alive_count + 1,
//                re-evaluated at every wrap; otherwise it is FRAMES_PER_STEP.
// -----------------------------------------------------------------------------
module invader_renderer #(
    parameter int COLS            = 8,
    parameter int ROWS            = 4,
    parameter int SPR_W           = 16,
    parameter int SPR_H           = 8,
    parameter int SPACE_X_LOG2    = 5,
    parameter int SPACE_Y_LOG2    = 4,
    parameter int START_X         = 16,
    parameter int START_Y         = 32,
    parameter int STEP_X          = 8,
    parameter int STEP_Y          = 16,
    parameter int FRAMES_PER_STEP = 30,
    parameter int SCREEN_W        = 800,
    parameter int LAND_Y          = 560
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                vsync,
    invader_renderer_if.slave   bus,
    output logic [10:0]         formation_x,
    output logic [10:0]         formation_y,
    output logic [5:0]          alive_count,
    output logic                step_pulse,
    output logic                landed,
    output logic                all_dead
);

    localparam int FORM_W = (COLS - 1) * (1 << SPACE_X_LOG2) + SPR_W;
    localparam int FORM_H = (ROWS - 1) * (1 << SPACE_Y_LOG2) + SPR_H;

    // The alive bitmap is always a full 4x8 grid indexed by {row, col}.
    // Cells outside ROWS x COLS start at 0 and can only ever be cleared, so an
    // out-of-range kill simply finds a dead cell and is ignored.
    function automatic logic [31:0] initAlive();
        logic [31:0] mask;
        mask = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r < ROWS && c < COLS) begin
                    mask[r*8 + c] = 1'b1;
                end
            end
        end
        return mask;
    endfunction

    localparam logic [31:0] ALIVE_INIT = initAlive();

    // Sprite ROM row lookup: two 16x8 frames that differ only in the legs.
    function automatic logic [15:0] spriteRow(input logic frame, input logic [2:0] y);
        logic [15:0] bits;
        case (y)
            3'd0:                    bits = 16'h0000;
            3'd1:                    bits = 16'h07E0;
            3'd2, 3'd3, 3'd4, 3'd5:  bits = 16'h3FFC;
            3'd6:                    bits = 16'h0C30;
            default:                 bits = frame ? 16'h6006 : 16'h1818;
        endcase
        return bits;
    endfunction

    typedef enum logic [2:0] {
        MOVE_R,
        MOVE_L,
        DOWN_L,
        DOWN_R,
        HALT
    } formState_t;

    formState_t  state;
    formState_t  stateNext;
    logic [10:0] fxNext;
    logic [10:0] fyNext;
    logic        landNext;

    logic        vsyncQ;
    logic        tick;
    logic [6:0]  frameCnt;
    logic [6:0]  periodLast;
    logic        frameWrap;
    logic        stepNow;
    logic        anim;

    logic [31:0] alive;
    logic        killHit;

    logic [10:0] relX;
    logic [10:0] relY;
    logic        inBox;
    logic [10:0] s1RelX;
    logic [10:0] s1RelY;
    logic        s1InBox;
    logic        s1Draw;
    logic        s1Anim;
    logic [31:0] s1Alive;

    logic [2:0]  cellCol;
    logic [1:0]  cellRow;
    logic [SPACE_X_LOG2-1:0] offX;
    logic [SPACE_Y_LOG2-1:0] offY;
    logic [15:0] spriteBits;
    logic        hit;
    logic [7:0]  pixelColour;

    // A frame tick is the rising edge of vsync.  The counter wraps on the tick
    // that reaches the last frame of the period, and that same tick issues the
    // formation step unless the formation has halted.  Using >= for the wrap
    // keeps the counter safe when the speed-up period shrinks below it.
    assign tick = vsync & ~vsyncQ;
`ifdef SPEEDUP_EN
    assign periodLast = {1'b0, alive_count};
`else
    assign periodLast = 7'(FRAMES_PER_STEP - 1);
`endif
    assign frameWrap = frameCnt >= periodLast;
    assign stepNow   = tick & frameWrap & (state != HALT);
    assign all_dead  = (alive_count == 6'd0);

    // Frame counter and the vsync edge detector.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            vsyncQ   <= 1'b0;
            frameCnt <= '0;
        end else begin
            vsyncQ <= vsync;
            if (tick) begin
                frameCnt <= frameWrap ? 7'd0 : frameCnt + 7'd1;
            end
        end
    end

    // Every step produces one step_pulse and flips the sprite animation frame.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            step_pulse <= 1'b0;
            anim       <= 1'b0;
        end else begin
            step_pulse <= stepNow;
            if (stepNow) begin
                anim <= ~anim;
            end
        end
    end

    // Marching FSM.  The step that finds the screen edge only changes state;
    // the following step drops the formation and reverses direction.  Landing
    // is judged on the position the step produces, and a wiped-out formation
    // halts regardless of any step.
    always_comb begin
        stateNext = state;
        fxNext    = formation_x;
        fyNext    = formation_y;
        landNext  = 1'b0;
        if (stepNow) begin
            case (state)
                MOVE_R: begin
                    if ({1'b0, formation_x} + 12'(STEP_X + FORM_W) > 12'(SCREEN_W)) begin
                        stateNext = DOWN_L;
                    end else begin
                        fxNext = formation_x + 11'(STEP_X);
                    end
                end
                MOVE_L: begin
                    if (formation_x < 11'(STEP_X)) begin
                        stateNext = DOWN_R;
                    end else begin
                        fxNext = formation_x - 11'(STEP_X);
                    end
                end
                DOWN_L: begin
                    fyNext    = formation_y + 11'(STEP_Y);
                    stateNext = MOVE_L;
                end
                DOWN_R: begin
                    fyNext    = formation_y + 11'(STEP_Y);
                    stateNext = MOVE_R;
                end
                default: begin
                end
            endcase
            if ({1'b0, fyNext} + 12'(FORM_H) >= 12'(LAND_Y)) begin
                stateNext = HALT;
                landNext  = 1'b1;
            end
        end
        if (all_dead) begin
            stateNext = HALT;
        end
    end

    // FSM state, formation position and the sticky landed flag.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state       <= MOVE_R;
            formation_x <= 11'(START_X);
            formation_y <= 11'(START_Y);
            landed      <= 1'b0;
        end else begin
            state       <= stateNext;
            formation_x <= fxNext;
            formation_y <= fyNext;
            landed      <= landed | landNext;
        end
    end

    // A kill only lands on a live cell, so repeats and out-of-range requests
    // leave both the bitmap and the count untouched.  Kills are independent of
    // the FSM and keep working after the formation halts.
    assign killHit = bus.kill_valid & alive[{bus.kill_row, bus.kill_col}];

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            alive       <= ALIVE_INIT;
            alive_count <= 6'(ROWS * COLS);
        end else if (killHit) begin
            alive[{bus.kill_row, bus.kill_col}] <= 1'b0;
            alive_count                         <= alive_count - 6'd1;
        end
    end

    // Stage 1: position of the pixel relative to the formation plus a bounding
    // box test.  Formation position, alive bitmap and animation frame are
    // captured alongside the pixel so stage 2 sees a consistent snapshot.
    assign relX  = bus.pixelx - formation_x;
    assign relY  = bus.pixely - formation_y;
    assign inBox = bus.draw
                 & (bus.pixelx >= formation_x)
                 & (bus.pixely >= formation_y)
                 & (relX < 11'(FORM_W))
                 & (relY < 11'(FORM_H));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            s1RelX  <= '0;
            s1RelY  <= '0;
            s1InBox <= 1'b0;
            s1Draw  <= 1'b0;
            s1Anim  <= 1'b0;
            s1Alive <= '0;
        end else begin
            s1RelX  <= relX;
            s1RelY  <= relY;
            s1InBox <= inBox;
            s1Draw  <= bus.draw;
            s1Anim  <= anim;
            s1Alive <= alive;
        end
    end

    // Stage 2: split the relative position into cell and in-cell offset, then
    // look up the sprite.  Offsets beyond the sprite fall in the gap between
    // cells.  Colour depends only on the row of the hit cell.
    assign cellCol    = s1RelX[SPACE_X_LOG2 +: 3];
    assign cellRow    = s1RelY[SPACE_Y_LOG2 +: 2];
    assign offX       = s1RelX[SPACE_X_LOG2-1:0];
    assign offY       = s1RelY[SPACE_Y_LOG2-1:0];
    assign spriteBits = spriteRow(s1Anim, offY[2:0]);
    assign hit        = s1InBox
                      & (int'(offX) < SPR_W)
                      & (int'(offY) < SPR_H)
                      & s1Alive[{cellRow, cellCol}]
                      & spriteBits[offX[3:0]];

    always_comb begin
        pixelColour = 8'h00;
        if (hit) begin
            if (cellRow == 2'd0) begin
                pixelColour = 8'hFF;
            end else if (cellRow == 2'd3) begin
                pixelColour = 8'h1C;
            end else begin
                pixelColour = 8'h1F;
            end
        end
    end

    // Output registers of the render pipeline.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            bus.rgb       <= 8'h00;
            bus.rgb_valid <= 1'b0;
        end else begin
            bus.rgb       <= pixelColour;
            bus.rgb_valid <= s1Draw;
        end
    end

endmodule

// File: tb/tb_invader_renderer.sv
// -----------------------------------------------------------------------------
// tb_invader_renderer
//
// Self-checking bench for invader_renderer.  A main instance with default
// parameters covers rendering, kills and marching; a second instance that
// steps on every frame covers the long march down to the landing line.
// Expected values come from a formation model kept in plain arithmetic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_invader_renderer;

    typedef struct {
        int fx;
        int fy;
        int dir;
        bit dropPending;
        bit halted;
        bit landed;
        bit anim;
    } formation_t;

    typedef struct {
        logic [7:0] rgb;
        logic       valid;
    } pix_t;

    logic        clk;
    logic        clear_n;
    logic        vsyncA;
    logic        vsyncB;
    logic [10:0] fxA, fyA, fxB, fyB;
    logic [5:0]  aliveA, aliveB;
    logic        stepPulseA, stepPulseB;
    logic        landedA, landedB;
    logic        allDeadA, allDeadB;

    invader_renderer_if busA ();
    invader_renderer_if busB ();

    invader_renderer dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .vsync       (vsyncA),
        .bus         (busA),
        .formation_x (fxA),
        .formation_y (fyA),
        .alive_count (aliveA),
        .step_pulse  (stepPulseA),
        .landed      (landedA),
        .all_dead    (allDeadA)
    );

    invader_renderer #(.FRAMES_PER_STEP(1)) dutFast (
        .clk         (clk),
        .clear_n     (clear_n),
        .vsync       (vsyncB),
        .bus         (busB),
        .formation_x (fxB),
        .formation_y (fyB),
        .alive_count (aliveB),
        .step_pulse  (stepPulseB),
        .landed      (landedB),
        .all_dead    (allDeadB)
    );

    int testCount = 0;
    int failCount = 0;

    formation_t fA, fB;
    bit         aliveMA [4][8];
    bit         aliveMB [4][8];
    int         aliveCntA, aliveCntB;
    int         framesA, framesB;
    int         stepsA, stepsB;
    int         pulsesA, pulsesB;
    int         strayPulse;

    // 40 MHz pixel clock.
    initial clk = 1'b0;
    always #12.5 clk = ~clk;

    // Hard stop in case anything stalls.
    initial begin
        #5ms;
        $display("[TB] FAIL timeout: simulation did not finish, observed running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic formation_t freshFormation();
        formation_t f;
        f.fx = 16; f.fy = 32; f.dir = 1;
        f.dropPending = 0; f.halted = 0; f.landed = 0; f.anim = 0;
        return f;
    endfunction

    // One formation step as described in behavioural terms: drop after an
    // edge was found, otherwise either find the edge or slide by 8 px.
    function automatic formation_t modelStep(formation_t f);
        if (f.halted) return f;
        f.anim = ~f.anim;
        if (f.dropPending) begin
            f.fy += 16;
            f.dropPending = 0;
            f.dir = -f.dir;
        end else if (f.dir > 0 && f.fx + 8 + 240 > 800) begin
            f.dropPending = 1;
        end else if (f.dir < 0 && f.fx < 8) begin
            f.dropPending = 1;
        end else begin
            f.fx += 8 * f.dir;
        end
        if (f.fy + 56 >= 560) begin
            f.halted = 1;
            f.landed = 1;
        end
        return f;
    endfunction

    function automatic bit spriteBit(bit frame, int oy, int ox);
        if (oy >= 2 && oy <= 5) return (ox >= 2 && ox <= 13);
        if (oy == 1) return (ox >= 5 && ox <= 10);
        if (oy == 6) return (ox == 4 || ox == 5 || ox == 10 || ox == 11);
        if (oy == 7) begin
            if (frame) return (ox == 1 || ox == 2 || ox == 13 || ox == 14);
            return (ox == 3 || ox == 4 || ox == 11 || ox == 12);
        end
        return 0;
    endfunction

    function automatic logic [7:0] expectedRgb(int px, int py, bit d);
        int rx, ry, col, row, ox, oy;
        if (!d) return 8'h00;
        if (px < fA.fx || py < fA.fy) return 8'h00;
        rx = px - fA.fx;
        ry = py - fA.fy;
        if (rx >= 240 || ry >= 56) return 8'h00;
        col = rx / 32; ox = rx % 32;
        row = ry / 16; oy = ry % 16;
        if (ox >= 16 || oy >= 8) return 8'h00;
        if (!aliveMA[row][col]) return 8'h00;
        if (!spriteBit(fA.anim, oy, ox)) return 8'h00;
        if (row == 0) return 8'hFF;
        if (row == 3) return 8'h1C;
        return 8'h1F;
    endfunction

    function automatic int periodA();
`ifdef SPEEDUP_EN
        return aliveCntA + 1;
`else
        return 30;
`endif
    endfunction

    function automatic int periodB();
`ifdef SPEEDUP_EN
        return aliveCntB + 1;
`else
        return 1;
`endif
    endfunction

    task automatic resetModel();
        fA = freshFormation();
        fB = freshFormation();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                aliveMA[r][c] = 1;
                aliveMB[r][c] = 1;
            end
        end
        aliveCntA = 32; aliveCntB = 32;
        framesA = 0; framesB = 0;
        stepsA = 0; stepsB = 0;
        pulsesA = 0; pulsesB = 0;
    endtask

    task automatic modelKillA(input int r, input int c);
        if (aliveMA[r][c]) begin
            aliveMA[r][c] = 0;
            aliveCntA--;
            if (aliveCntA == 0) fA.halted = 1;
        end
    endtask

    task automatic modelKillB(input int r, input int c);
        if (aliveMB[r][c]) begin
            aliveMB[r][c] = 0;
            aliveCntB--;
            if (aliveCntB == 0) fB.halted = 1;
        end
    endtask

    task automatic killInvaderA(input int r, input int c);
        @(negedge clk);
        busA.kill_valid = 1'b1;
        busA.kill_row   = 2'(r);
        busA.kill_col   = 3'(c);
        modelKillA(r, c);
        @(negedge clk);
        busA.kill_valid = 1'b0;
    endtask

    task automatic killInvaderB(input int r, input int c);
        @(negedge clk);
        busB.kill_valid = 1'b1;
        busB.kill_row   = 2'(r);
        busB.kill_col   = 3'(c);
        modelKillB(r, c);
        @(negedge clk);
        busB.kill_valid = 1'b0;
    endtask

    // One vsync pulse on the main instance, optionally with a kill on the
    // same clock edge.  The step decision uses the count before the kill.
    task automatic frameTickA(input bit withKill, input int kr, input int kc);
        @(negedge clk);
        if (stepPulseA !== 1'b0) strayPulse++;
        vsyncA = 1'b1;
        if (withKill) begin
            busA.kill_valid = 1'b1;
            busA.kill_row   = 2'(kr);
            busA.kill_col   = 3'(kc);
        end
        framesA++;
        if (framesA >= periodA()) begin
            framesA = 0;
            if (!fA.halted) begin
                fA = modelStep(fA);
                stepsA++;
            end
        end
        if (withKill) modelKillA(kr, kc);
        @(negedge clk);
        vsyncA = 1'b0;
        busA.kill_valid = 1'b0;
        if (stepPulseA === 1'b1) pulsesA++;
    endtask

    task automatic frameTickB();
        @(negedge clk);
        if (stepPulseB !== 1'b0) strayPulse++;
        vsyncB = 1'b1;
        framesB++;
        if (framesB >= periodB()) begin
            framesB = 0;
            if (!fB.halted) begin
                fB = modelStep(fB);
                stepsB++;
            end
        end
        @(negedge clk);
        vsyncB = 1'b0;
        if (stepPulseB === 1'b1) pulsesB++;
    endtask

    // Step the main instance until the model has made the target number of
    // steps; optionally put a kill on the edge of the final step.
    task automatic advanceTo(input int target, input bit killOnLast, input int kr, input int kc);
        int  guard;
        bit  willStep;
        guard = 0;
        while (stepsA < target && guard < 4000) begin
            willStep = !fA.halted && (framesA + 1 >= periodA());
            frameTickA(killOnLast && willStep && (stepsA == target - 1), kr, kc);
            guard++;
        end
        checkOutput($sformatf("pulsesAtStep%0d", target), pulsesA, target);
    endtask

    // Single directed pixel: drive, wait out the two-cycle latency, compare.
    task automatic applyStimulus(input int px, input int py, input bit d, input string tag);
        logic [7:0] expRgb;
        @(negedge clk);
        busA.draw   = d;
        busA.pixelx = 11'(px);
        busA.pixely = 11'(py);
        expRgb = expectedRgb(px, py, d);
        @(negedge clk);
        @(negedge clk);
        checkOutput({tag, "Rgb"}, busA.rgb, expRgb);
        checkOutput({tag, "Valid"}, busA.rgb_valid, d);
        busA.draw = 1'b0;
    endtask

    // Back-to-back random pixels around the formation, one per clock.
    task automatic randomPixels(input int n);
        pix_t q[$];
        pix_t e;
        pix_t got;
        int   px, py;
        bit   d;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (q.size() >= 2) begin
                e = q.pop_front();
                got.rgb = busA.rgb;
                got.valid = busA.rgb_valid;
                checkOutput("streamRgb", got.rgb, e.rgb);
                checkOutput("streamValid", got.valid, e.valid);
            end
            if (i < n) begin
                px = fA.fx + int'($urandom_range(270, 0)) - 15;
                py = fA.fy + int'($urandom_range(66, 0)) - 5;
                if (px < 0) px = 0;
                if (px > 799) px = 799;
                if (py < 0) py = 0;
                if (py > 599) py = 599;
                d = ($urandom_range(7, 0) != 0);
            end else begin
                px = 0; py = 0; d = 0;
            end
            busA.draw   = d;
            busA.pixelx = 11'(px);
            busA.pixely = 11'(py);
            e.rgb   = expectedRgb(px, py, d);
            e.valid = d;
            q.push_back(e);
        end
        busA.draw = 1'b0;
    endtask

    initial begin
        int fxHold;
        int ticks;
        int p0;

        clear_n = 1'b0;
        vsyncA = 1'b0; vsyncB = 1'b0;
        busA.draw = 1'b0; busA.pixelx = '0; busA.pixely = '0;
        busA.kill_valid = 1'b0; busA.kill_row = '0; busA.kill_col = '0;
        busB.draw = 1'b0; busB.pixelx = '0; busB.pixely = '0;
        busB.kill_valid = 1'b0; busB.kill_row = '0; busB.kill_col = '0;
        strayPulse = 0;
        resetModel();

        #60;
        checkOutput("resetRgb", busA.rgb, 8'h00);
        checkOutput("resetRgbValid", busA.rgb_valid, 1'b0);
        checkOutput("resetFx", fxA, 16);
        checkOutput("resetFy", fyA, 32);
        checkOutput("resetAlive", aliveA, 32);
        checkOutput("resetStepPulse", stepPulseA, 1'b0);
        checkOutput("resetLanded", landedA, 1'b0);
        checkOutput("resetAllDead", allDeadA, 1'b0);

        @(negedge clk);
        clear_n = 1'b1;

        $display("[TB] rendering at reset position");
        applyStimulus(16 + 7, 32 + 3, 1, "rowZeroBody");
        checkOutput("rowZeroIsWhite", busA.rgb, 8'hFF);
        applyStimulus(16 + 16, 32 + 3, 1, "cellGap");
        applyStimulus(16 + 3, 32 + 7, 1, "legFrame0");
        applyStimulus(16 + 7, 32 + 3, 0, "noDraw");
        applyStimulus(16 + 7, 32 + 16 + 3, 1, "rowOneColour");
        applyStimulus(16 + 32*7 + 13, 32 + 48 + 5, 1, "rowThreeColour");
        applyStimulus(16 + 240, 32 + 3, 1, "rightOfBox");
        randomPixels(200);

        $display("[TB] first step");
        for (int i = 0; i < 30; i++) frameTickA(0, 0, 0);
        checkOutput("firstStepPulses", pulsesA, stepsA);
        checkOutput("firstStepFx", fxA, fA.fx);
        applyStimulus(fA.fx + 3, fA.fy + 7, 1, "legAfterStep");
        applyStimulus(fA.fx + 1, fA.fy + 7, 1, "legAltFrame");

        $display("[TB] kills");
        killInvaderA(0, 0);
        checkOutput("killFirst", aliveA, aliveCntA);
        applyStimulus(fA.fx + 7, fA.fy + 3, 1, "killedCell");
        killInvaderA(0, 0);
        checkOutput("killRepeat", aliveA, aliveCntA);
        killInvaderA(3, 7);
        checkOutput("killCorner", aliveA, aliveCntA);
        for (int i = 0; i < 4; i++) killInvaderA(int'($urandom_range(3, 0)), int'($urandom_range(7, 0)));
        checkOutput("killRandom", aliveA, aliveCntA);
        randomPixels(200);

        $display("[TB] marching to the right edge");
        advanceTo(68, 0, 0, 0);
        checkOutput("fxAtStep68", fxA, 560);
        advanceTo(69, 0, 0, 0);
        checkOutput("fxAtStep69", fxA, 560);
        checkOutput("fyAtStep69", fyA, 32);
        advanceTo(70, 0, 0, 0);
        checkOutput("fyAtStep70", fyA, 48);
        advanceTo(71, 1, 1, 2);
        checkOutput("fxAtStep71", fxA, 552);
        checkOutput("killWithStep", aliveA, aliveCntA);
        randomPixels(150);

        $display("[TB] wiping out the formation");
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) killInvaderA(r, c);
        end
        checkOutput("allKilledCount", aliveA, 0);
        checkOutput("allDeadFlag", allDeadA, 1'b1);
        fxHold = fA.fx;
        for (int i = 0; i < 70; i++) frameTickA(0, 0, 0);
        checkOutput("haltNoPulse", pulsesA, stepsA);
        checkOutput("haltNoMove", fxA, fxHold);
        randomPixels(40);

        $display("[TB] marching down to the landing line");
`ifdef SPEEDUP_EN
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (!(r == 3 && c == 7)) killInvaderB(r, c);
            end
        end
`endif
        ticks = 0;
        while (!fB.landed && ticks < 9000) begin
            frameTickB();
            ticks++;
        end
        checkOutput("landedFlag", landedB, 1'b1);
        checkOutput("landedFy", fyB, 512);
        checkOutput("landedFyModel", fyB, fB.fy);
        checkOutput("landedFx", fxB, fB.fx);
        checkOutput("landingPulses", pulsesB, stepsB);
        p0 = pulsesB;
        for (int i = 0; i < 10; i++) frameTickB();
        checkOutput("noPulseAfterLanding", pulsesB, p0);
        checkOutput("landedSticky", landedB, 1'b1);
`ifdef SPEEDUP_EN
        killInvaderB(3, 7);
`else
        killInvaderB(1, 1);
`endif
        checkOutput("killDuringHalt", aliveB, aliveCntB);

        $display("[TB] reset in the middle of a frame");
        frameTickA(0, 0, 0);
        @(posedge clk);
        #5;
        clear_n = 1'b0;
        #1;
        checkOutput("midResetRgb", busA.rgb, 8'h00);
        checkOutput("midResetRgbValid", busA.rgb_valid, 1'b0);
        checkOutput("midResetFx", fxA, 16);
        checkOutput("midResetFy", fyA, 32);
        checkOutput("midResetAlive", aliveA, 32);
        checkOutput("midResetLanded", landedB, 1'b0);
        checkOutput("midResetFyFast", fyB, 32);
        resetModel();
        @(negedge clk);
        clear_n = 1'b1;
        applyStimulus(16 + 7, 32 + 3, 1, "afterResetBody");

        $display("[TB] step period with 31 alive");
        killInvaderA(2, 4);
        ticks = 0;
        p0 = pulsesA;
        while (pulsesA == p0 && ticks < 100) begin
            frameTickA(0, 0, 0);
            ticks++;
        end
`ifdef SPEEDUP_EN
        checkOutput("periodWith31Alive", ticks, 32);
`else
        checkOutput("periodWith31Alive", ticks, 30);
`endif
        checkOutput("strayPulses", strayPulse, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
